// File: rtl/led_shift_ctrl.sv
// ---------------------------------------------------------------------------
// led_shift_ctrl
//
// Drives the enable and direction of an external LED shift register and
// mirrors the position of the single lit LED.
//
// A programmable prescaler produces a one-cycle strobe every LIMsel clocks
// while the FSM is in RUN. A debounced button toggles the shift direction on
// each rising edge.
//
// Optional feature:
//   LED_SHIFT_PINGPONG_EN - when defined, the direction reverses at the ends
//   of the LED row, so the lit LED bounces back and forth. When undefined,
//   the lit LED rotates with wrap-around and only the button changes the
//   direction.
//
// Parameters:
//   NB_LEDS   - number of LEDs in the controlled shift register
//   NB_COUNT  - prescaler width
//   LIM0..3   - shift period in clocks for i_speed = 0..3 (each >= 2)
//
// Ports:
//   clock        in   sole clock, rising edge
//   i_reset      in   synchronous active-high reset
//   i_run        in   level: 1 = run, 0 = hold
//   i_speed      in   [1:0] period select
//   i_btn_dir    in   debounced button; each rising edge toggles direction
//   o_enable     out  one-cycle shift strobe
//   o_shift_dir  out  1 = left (toward MSB), 0 = right
//   o_pos        out  index of the lit LED
//   o_state      out  FSM state: IDLE=0, RUN=1, HOLD=2
// ---------------------------------------------------------------------------
module led_shift_ctrl #(
  parameter int                  NB_LEDS  = 4,
  parameter int                  NB_COUNT = 32,
  parameter logic [NB_COUNT-1:0] LIM0     = NB_COUNT'(2**25),
  parameter logic [NB_COUNT-1:0] LIM1     = NB_COUNT'(2**24),
  parameter logic [NB_COUNT-1:0] LIM2     = NB_COUNT'(2**23),
  parameter logic [NB_COUNT-1:0] LIM3     = NB_COUNT'(2**22),
  localparam int                 POS_W    = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic [1:0]       i_speed,
  input  logic             i_btn_dir,
  output logic             o_enable,
  output logic             o_shift_dir,
  output logic [POS_W-1:0] o_pos,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NB_LEDS - 1);

  state_t              state;
  state_t              state_next;
  logic [NB_COUNT-1:0] count;
  logic [NB_COUNT-1:0] lim_sel;
  logic [NB_COUNT-1:0] lim_last;
  logic [1:0]          speed;
  logic                btn_prev;
  logic                btn_rise;
  logic                dir;
  logic                strobe;
  logic [POS_W-1:0]    pos;
  logic [POS_W-1:0]    pos_next;

  // State register.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE is only re-entered through reset.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_run)  state_next = RUN;
      RUN:     if (!i_run) state_next = HOLD;
      HOLD:    if (i_run)  state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded only from registers, so o_enable is glitch-free.
  always_comb begin
    o_state     = state;
    o_enable    = strobe;
    o_shift_dir = dir;
    o_pos       = pos;
  end

  // The speed select is registered so the strobe never depends on an
  // unregistered input path.
  always_comb begin
    lim_sel = LIM0;
    case (speed)
      2'd0: lim_sel = LIM0;
      2'd1: lim_sel = LIM1;
      2'd2: lim_sel = LIM2;
      2'd3: lim_sel = LIM3;
      default: lim_sel = LIM0;
    endcase
    lim_last = lim_sel - NB_COUNT'(1);
    // ">=" rather than "==": switching to a shorter period mid-count fires
    // immediately instead of waiting for the counter to wrap.
    strobe = (state == RUN) && (count >= lim_last);
  end

  // Prescaler: cleared in IDLE, counts in RUN, frozen in HOLD.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      count <= '0;
    end else begin
      case (state)
        IDLE:    count <= '0;
        RUN:     count <= strobe ? '0 : count + NB_COUNT'(1);
        HOLD:    count <= count;
        default: count <= '0;
      endcase
    end
  end

  assign btn_rise = i_btn_dir & ~btn_prev;

  // Position after one shift in the current direction, wrapping at both ends.
  always_comb begin
    pos_next = pos;
    if (dir) begin
      pos_next = (pos == POS_MAX) ? '0 : pos + POS_W'(1);
    end else begin
      pos_next = (pos == '0) ? POS_MAX : pos - POS_W'(1);
    end
  end

  // Position and direction. A strobe always shifts with the direction held
  // before this edge; a button toggle only affects later strobes.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      btn_prev <= 1'b0;
      speed    <= 2'd0;
      dir      <= 1'b1;
      pos      <= '0;
    end else begin
      btn_prev <= i_btn_dir;
      speed    <= i_speed;
      if (strobe) begin
        pos <= pos_next;
      end
`ifdef LED_SHIFT_PINGPONG_EN
      // Reaching an end of the row reverses the direction; that reversal
      // overrides any button edge arriving on the same clock.
      if (strobe && dir && (pos_next == POS_MAX)) begin
        dir <= 1'b0;
      end else if (strobe && !dir && (pos_next == '0)) begin
        dir <= 1'b1;
      end else if (btn_rise) begin
        dir <= ~dir;
      end
`else
      if (btn_rise) begin
        dir <= ~dir;
      end
`endif
    end
  end

endmodule

// File: tb/tb_led_shift_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_shift_ctrl
//
// Scoreboard bench for led_shift_ctrl (NB_LEDS=4, periods 4/8/16/32).
// The stimulus process drives inputs on the falling edge, advances a
// behavioural model by one clock and queues the outputs expected after the
// next rising edge. An independent monitor pops one record per rising edge
// and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_led_shift_ctrl;

  localparam int N = 4;

  logic       clock     = 1'b0;
  logic       i_reset   = 1'b1;
  logic       i_run     = 1'b0;
  logic [1:0] i_speed   = 2'd0;
  logic       i_btn_dir = 1'b0;
  logic       o_enable;
  logic       o_shift_dir;
  logic [1:0] o_pos;
  logic [1:0] o_state;

  int vectors     = 0;
  int miscompares = 0;

  int lims [4] = '{4, 8, 16, 32};

  typedef struct {
    bit en;
    int st;
    int pos;
    bit dir;
  } exp_t;

  exp_t exp_q [$];

  // Reference model: state 0 idle, 1 running, 2 held; run_cycles counts
  // running clocks since the last shift.
  int m_state;
  int m_run_cycles;
  int m_pos;
  int m_speed;
  bit m_dir;
  bit m_btn;

  led_shift_ctrl #(
    .NB_LEDS (N),
    .NB_COUNT(32),
    .LIM0    (32'd4),
    .LIM1    (32'd8),
    .LIM2    (32'd16),
    .LIM3    (32'd32)
  ) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_run      (i_run),
    .i_speed    (i_speed),
    .i_btn_dir  (i_btn_dir),
    .o_enable   (o_enable),
    .o_shift_dir(o_shift_dir),
    .o_pos      (o_pos),
    .o_state    (o_state)
  );

  always #5 clock = ~clock;

  function automatic bit model_shift_due();
    return (m_state == 1) && (m_run_cycles >= lims[m_speed] - 1);
  endfunction

  task automatic model_step(input bit rst, input bit run, input int spd, input bit btn);
    bit shift;
    bit btn_rise;
    int new_pos;
    bit new_dir;
    if (rst) begin
      m_state      = 0;
      m_run_cycles = 0;
      m_pos        = 0;
      m_dir        = 1'b1;
      m_btn        = 1'b0;
      m_speed      = 0;
    end else begin
      shift    = model_shift_due();
      btn_rise = btn && !m_btn;
      new_pos  = m_pos;
      if (shift) new_pos = m_dir ? (m_pos + 1) % N : (m_pos + N - 1) % N;
      new_dir = m_dir ^ btn_rise;
`ifdef LED_SHIFT_PINGPONG_EN
      if (shift && m_dir && new_pos == N - 1) new_dir = 1'b0;
      else if (shift && !m_dir && new_pos == 0) new_dir = 1'b1;
`endif
      if (m_state == 0) m_run_cycles = 0;
      else if (m_state == 1) m_run_cycles = shift ? 0 : m_run_cycles + 1;
      if (m_state == 0) m_state = run ? 1 : 0;
      else m_state = run ? 1 : 2;
      m_pos   = new_pos;
      m_dir   = new_dir;
      m_btn   = btn;
      m_speed = spd;
    end
  endtask

  task automatic apply_stimulus(input bit rst, input bit run, input logic [1:0] spd, input bit btn);
    exp_t e;
    @(negedge clock);
    i_reset   = rst;
    i_run     = run;
    i_speed   = spd;
    i_btn_dir = btn;
    model_step(rst, run, int'(spd), btn);
    e.en  = model_shift_due();
    e.st  = m_state;
    e.pos = m_pos;
    e.dir = m_dir;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input exp_t e);
    vectors++;
    if (o_enable !== e.en) begin
      miscompares++;
      $display("[TB] FAIL enable at %0t: got %b expected %b", $time, o_enable, e.en);
    end
    vectors++;
    if (o_state !== 2'(e.st)) begin
      miscompares++;
      $display("[TB] FAIL state at %0t: got %0d expected %0d", $time, o_state, e.st);
    end
    vectors++;
    if (o_pos !== 2'(e.pos)) begin
      miscompares++;
      $display("[TB] FAIL pos at %0t: got %0d expected %0d", $time, o_pos, e.pos);
    end
    vectors++;
    if (o_shift_dir !== e.dir) begin
      miscompares++;
      $display("[TB] FAIL dir at %0t: got %b expected %b", $time, o_shift_dir, e.dir);
    end
  endtask

  // Monitor: one expected record per rising edge once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    bit         btn_level;
    logic [1:0] spd;
    bit         rst;
    bit         run;
    btn_level = 1'b0;
    spd       = 2'd0;

    // Reset, then run at the fastest period.
    repeat (2) apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
    repeat (24) apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);

    // Slow period partway through, then switch to the fastest one.
    apply_stimulus(1'b1, 1'b0, 2'd3, 1'b0);
    repeat (22) apply_stimulus(1'b0, 1'b1, 2'd3, 1'b0);
    repeat (12) apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);

    // Hold mid-count, then resume.
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
    repeat (3) apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
    repeat (10) apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
    repeat (10) apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);

    // Button press on a shift cycle: strobe falls on cycles 4, 8, ... after run.
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
    repeat (7) apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 2'd0, 1'b1);
    repeat (8) apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      run = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) spd = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) btn_level = ~btn_level;
      apply_stimulus(rst, run, spd, btn_level);
    end

    @(posedge clock);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending records expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
